// File: rtl/sd_frame_pkg.sv
// Shared types and constants for the SD frame loader.
package sd_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    ISSUE,
    RECV,
    FINISH
  } state_t;

  localparam int ADLER_MOD        = 65521;
  localparam int DEF_SECTOR_BYTES = 512;

  // Bits needed to index n entries; never returns less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((longint'(1) << r) < longint'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/mod65521_acc.sv
// Running sum modulo 65521 using only compare/subtract steps.
module mod65521_acc
  import sd_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sum
);

  logic [16:0] p_ext, p_red, s_raw;
  logic [15:0] s_nxt;

  // Pre-reduce the pixel, add, then fold the sum back below the modulus.
  always_comb begin
    p_ext = {1'b0, din};
    p_red = (p_ext >= 17'(ADLER_MOD)) ? p_ext - 17'(ADLER_MOD) : p_ext;
    s_raw = {1'b0, sum} + p_red;
    s_nxt = (s_raw >= 17'(ADLER_MOD)) ? 16'(s_raw - 17'(ADLER_MOD)) : s_raw[15:0];
  end

  // Accumulator register; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (rst || clr) sum <= '0;
    else if (en)    sum <= s_nxt;
  end

endmodule

// File: rtl/sd_frame_loader.sv
// Loads one frame of consecutive SD sectors into the back bank of a
// multi-bank frame buffer, then swaps the displayed bank on success.
module sd_frame_loader
  import sd_frame_pkg::*;
#(
  parameter int PIX_BYTES    = 2,
  parameter int FRAME_PIXELS = 3072,
  parameter int NUM_BANKS    = 2,
  parameter int SECTOR_BYTES = DEF_SECTOR_BYTES,
  parameter int TIMEOUT      = 1 << 20,
  localparam int PIX_W  = 8 * PIX_BYTES,
  localparam int BANK_W = clog2(NUM_BANKS),
  localparam int AW     = clog2(NUM_BANKS * FRAME_PIXELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       base_sector,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       checksum,
  output logic [BANK_W-1:0] disp_bank,
  output logic              sd_rd,
  output logic [31:0]       sd_address,
  input  logic [7:0]        sd_dout,
  input  logic              sd_byte_available,
  input  logic              sd_ready,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [PIX_W-1:0]  wr_data
);

  localparam int SECTORS = FRAME_PIXELS * PIX_BYTES / SECTOR_BYTES;
  localparam int SI_W    = clog2(SECTORS);
  localparam int BC_W    = clog2(SECTOR_BYTES);
  localparam int PI_W    = clog2(FRAME_PIXELS);
  localparam int WD_W    = clog2(TIMEOUT);

  generate
    if ((FRAME_PIXELS * PIX_BYTES) % SECTOR_BYTES != 0) begin : g_bad_frame
      $error("frame size must be a whole number of sectors");
    end
    if (PIX_BYTES < 1 || PIX_BYTES > 2) begin : g_bad_pix
      $error("PIX_BYTES must be 1 or 2");
    end
    if (NUM_BANKS < 2) begin : g_bad_banks
      $error("NUM_BANKS must be at least 2");
    end
  endgenerate

  state_t            state, nxt;
  logic [31:0]       base;
  logic [BANK_W-1:0] load_bank, nxt_bank;
  logic [AW-1:0]     bank_base;
  logic [SI_W-1:0]   sector_idx;
  logic [BC_W-1:0]   byte_cnt;
  logic              pb_cnt;
  logic [PI_W-1:0]   pix_idx;
  logic              all_rcvd;
  logic [WD_W-1:0]   wd;
  logic [PIX_W-1:0]  pix_word;

  logic accept, byte_ok, sec_last, frame_last, pix_done;
  logic watching, progress, wd_fire;

  // Transaction qualifiers shared by the FSM and the datapath.
  always_comb begin
    accept     = (state == IDLE) && start && !abort;
    byte_ok    = (state == RECV) && !all_rcvd && sd_byte_available;
    sec_last   = byte_ok && (byte_cnt == BC_W'(SECTOR_BYTES - 1));
    frame_last = sec_last && (sector_idx == SI_W'(SECTORS - 1));
    pix_done   = byte_ok && ((PIX_BYTES == 1) || pb_cnt);
    watching   = (state == WAIT_READY) || ((state == RECV) && !all_rcvd);
    progress   = ((state == WAIT_READY) && sd_ready) || byte_ok;
    wd_fire    = watching && !progress && (wd == WD_W'(TIMEOUT - 1));
    nxt_bank   = (disp_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : disp_bank + 1'b1;
  end

  // First byte of a pixel is the MSB; hold it until the pixel completes.
  generate
    if (PIX_BYTES == 2) begin : g_p2
      logic [7:0] hi;
      always_ff @(posedge clk) begin
        if (rst)          hi <= '0;
        else if (byte_ok) hi <= sd_dout;
      end
      assign pix_word = {hi, sd_dout};
    end else begin : g_p1
      assign pix_word = sd_dout;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state and strobe outputs; abort overrides everything outside IDLE.
  always_comb begin
    nxt   = state;
    busy  = (state != IDLE);
    done  = (state == FINISH);
    sd_rd = (state == ISSUE);
    case (state)
      IDLE:       if (accept) nxt = WAIT_READY;
      WAIT_READY: if (sd_ready) nxt = ISSUE;
                  else if (wd_fire) nxt = IDLE;
      ISSUE:      nxt = RECV;
      RECV:       if (all_rcvd) nxt = FINISH;
                  else if (sec_last && !frame_last) nxt = WAIT_READY;
                  else if (wd_fire) nxt = IDLE;
      FINISH:     nxt = IDLE;
      default:    nxt = IDLE;
    endcase
    if (abort && state != IDLE) nxt = IDLE;
  end

  // Counters, sector addressing, pixel writes, watchdog and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      base       <= '0;
      load_bank  <= '0;
      bank_base  <= '0;
      sector_idx <= '0;
      byte_cnt   <= '0;
      pb_cnt     <= 1'b0;
      pix_idx    <= '0;
      all_rcvd   <= 1'b0;
      wd         <= '0;
      error      <= 1'b0;
      disp_bank  <= '0;
      sd_address <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= 1'b0;
      if (accept) begin
        base       <= base_sector;
        load_bank  <= nxt_bank;
        bank_base  <= AW'(int'(nxt_bank) * FRAME_PIXELS);
        sector_idx <= '0;
        byte_cnt   <= '0;
        pb_cnt     <= 1'b0;
        pix_idx    <= '0;
        all_rcvd   <= 1'b0;
        error      <= 1'b0;
      end
      if (state == WAIT_READY && nxt == ISSUE)
        sd_address <= base + 32'(sector_idx);
      if (byte_ok) begin
        byte_cnt <= byte_cnt + 1'b1;
        pb_cnt   <= !pix_done;
      end
      if (pix_done) begin
        wr_en   <= 1'b1;
        wr_addr <= bank_base + AW'(pix_idx);
        wr_data <= pix_word;
        pix_idx <= pix_idx + 1'b1;
      end
      if (sec_last) begin
        byte_cnt <= '0;
        if (frame_last) all_rcvd <= 1'b1;
        else            sector_idx <= sector_idx + 1'b1;
      end
      if (!watching || progress) wd <= '0;
      else                       wd <= wd + 1'b1;
      if (wd_fire && !abort) error <= 1'b1;
      // Swap on entry to FINISH so done, checksum and new bank coincide.
      if (state == RECV && nxt == FINISH) disp_bank <= load_bank;
    end
  end

  mod65521_acc u_acc (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (wr_en),
    .din (16'(wr_data)),
    .sum (checksum)
  );

endmodule

// File: tb/tb_sd_frame_loader.sv
// Bench for sd_frame_loader: randomized SD controller model, table of full
// frame loads, plus timeout, abort, ignored-start and reset sequences.
module tb_sd_frame_loader;

  localparam int TO       = 200;
  localparam int FP       = 3072;
  localparam int SECTOR_B = 512;
  localparam int NBYTES   = FP * 2;
  localparam int SECTORS  = NBYTES / SECTOR_B;
  localparam int BUDGET   = 20000;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [31:0] base_sector;
  logic        busy, done, error;
  logic [15:0] checksum;
  logic        disp_bank;
  logic        sd_rd;
  logic [31:0] sd_address;
  logic [7:0]  sd_dout;
  logic        sd_byte_available, sd_ready;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;

  sd_frame_loader #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_sector(base_sector),
    .busy(busy), .done(done), .error(error), .checksum(checksum), .disp_bank(disp_bank),
    .sd_rd(sd_rd), .sd_address(sd_address), .sd_dout(sd_dout),
    .sd_byte_available(sd_byte_available), .sd_ready(sd_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0, checks = 0;
  int fill_mode = 0;
  logic [31:0] cur_base = 0;
  int stall_sec = -1, stall_byte = 0;
  int last_byte_cyc = 0;
  logic [7:0] rnd_bytes [NBYTES];

  logic [31:0] rd_q[$];
  logic [12:0] wa_q[$];
  logic [15:0] wd_q[$];
  int done_cnt = 0, err_cyc = 0;
  logic err_q = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Byte n of the frame image for the current fill pattern.
  function automatic logic [7:0] byte_at(input int n);
    if (n < 0 || n >= NBYTES) return 8'h00;
    case (fill_mode)
      0:       return 8'(n % 256);
      1:       return 8'hFF;
      default: return rnd_bytes[n];
    endcase
  endfunction

  // Observe DUT transactions.
  always @(negedge clk) begin
    if (sd_rd) rd_q.push_back(sd_address);
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (error && !err_q) err_cyc <= cyc;
    err_q <= error;
  end

  // SD controller model: one sector per sd_rd, random gaps, spurious ready.
  initial begin : ctl
    int sec, i;
    sd_ready = 1'b1; sd_byte_available = 1'b0; sd_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (sd_rd) begin
        sec = int'(sd_address - cur_base);
        if (sec < 0 || sec >= SECTORS) sec = -1000;
        sd_ready = 1'b0;
        i = 0;
        while (i < SECTOR_B && busy) begin
          @(negedge clk);
          sd_byte_available = 1'b0;
          sd_ready = ($urandom_range(15) == 0);
          if (busy && !(sec == stall_sec && i >= stall_byte) && $urandom_range(7) != 0) begin
            sd_dout = byte_at(sec * SECTOR_B + i);
            sd_byte_available = 1'b1;
            last_byte_cyc = cyc;
            i++;
          end
        end
        @(negedge clk);
        sd_byte_available = 1'b0;
        sd_ready = 1'b0;
        repeat ($urandom_range(3)) @(negedge clk);
        sd_ready = 1'b1;
      end
    end
  end

  task automatic do_start(input logic [31:0] b);
    @(negedge clk);
    cur_base = b; base_sector = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One complete load, checked against the frame image model.
  task automatic run_load(input string tag, input logic [31:0] b, input int mode,
                          input bit poke, input int exp_ck, input int exp_bank);
    int r0, w0, d0, t, bad, n, dcyc;
    bit poked;
    fill_mode = mode;
    r0 = rd_q.size(); w0 = wa_q.size(); d0 = done_cnt;
    do_start(b);
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_err_clr"}, error, 0);
    t = 0; poked = 0;
    while (!done && t < BUDGET) begin
      @(negedge clk); t++;
      if (poke && !poked && !done && wa_q.size() - w0 >= 500) begin
        poked = 1; base_sector = 32'h0BAD_0000; start = 1'b1;
        @(negedge clk); start = 1'b0; t++;
      end
    end
    dcyc = cyc;
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_checksum"}, checksum, exp_ck);
    check({tag, "_disp_bank"}, disp_bank, exp_bank);
    check({tag, "_done_lat"}, dcyc - last_byte_cyc, 2);
    @(negedge clk);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_done_cnt"}, done_cnt - d0, 1);
    n = rd_q.size() - r0;
    check({tag, "_rd_cnt"}, n, SECTORS);
    bad = 0;
    for (int i = 0; i < n && i < SECTORS; i++)
      if (rd_q[r0 + i] !== b + 32'(i)) bad++;
    check({tag, "_rd_addr_bad"}, bad, 0);
    n = wa_q.size() - w0;
    check({tag, "_wr_cnt"}, n, FP);
    bad = 0;
    for (int k = 0; k < n && k < FP; k++)
      if (wa_q[w0 + k] !== 13'(exp_bank * FP + k) ||
          wd_q[w0 + k] !== {byte_at(2 * k), byte_at(2 * k + 1)}) bad++;
    check({tag, "_wr_bad"}, bad, 0);
  endtask

  typedef struct {
    logic [31:0] base;
    int          mode;
    bit          poke;
    int          exp_ck;
    int          exp_bank;
  } row_t;

  row_t rows [4];

  initial begin : main
    int t, d0, r0, w0;
    longint tot;
    rst = 1'b1; start = 1'b0; abort = 1'b0; base_sector = '0;

    for (int i = 0; i < NBYTES; i++) rnd_bytes[i] = 8'($urandom);
    tot = 0;
    for (int k = 0; k < FP; k++) tot += {rnd_bytes[2 * k], rnd_bytes[2 * k + 1]};
    rows[0] = '{32'd100,  0, 1'b0, 22950, 1};
    rows[1] = '{32'd40,   0, 1'b1, 22950, 0};
    rows[2] = '{32'd7000, 1, 1'b0, 43008, 1};
    rows[3] = '{32'($urandom_range(100000, 1000)), 2, 1'b0, int'(tot % 65521), 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_checksum", checksum, 0);
    check("rst_disp_bank", disp_bank, 0);
    check("rst_sd_rd", sd_rd, 0);
    check("rst_sd_address", sd_address, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);

    for (int r = 0; r < 4; r++)
      run_load($sformatf("row%0d", r), rows[r].base, rows[r].mode, rows[r].poke,
               rows[r].exp_ck, rows[r].exp_bank);

    // Controller stalls after 300 bytes of sector 3.
    fill_mode = 0; stall_sec = 3; stall_byte = 300;
    d0 = done_cnt; r0 = rd_q.size();
    do_start(200);
    t = 0;
    while (busy && t < BUDGET) begin @(negedge clk); t++; end
    check("to_busy", busy, 0);
    check("to_error", error, 1);
    check("to_disp_bank", disp_bank, 0);
    @(negedge clk);
    check("to_latency", err_cyc - last_byte_cyc, TO + 1);
    check("to_no_done", done_cnt - d0, 0);
    check("to_rd_cnt", rd_q.size() - r0, 4);
    stall_sec = -1;
    run_load("after_to", 32'd300, 0, 1'b0, 22950, 1);

    // Abort around pixel 1000.
    d0 = done_cnt; w0 = wa_q.size();
    do_start(500);
    t = 0;
    while (wa_q.size() - w0 < 1000 && t < BUDGET) begin @(negedge clk); t++; end
    check("abort_reached", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_disp_bank", disp_bank, 1);
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_error", error, 0);

    // start and abort together while idle.
    r0 = rd_q.size();
    @(negedge clk);
    base_sector = 32'd900; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("sa_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("sa_no_rd", rd_q.size() - r0, 0);

    // Reset in the middle of sector 5.
    fill_mode = 0; r0 = rd_q.size();
    do_start(600);
    t = 0;
    while (rd_q.size() - r0 < 6 && t < BUDGET) begin @(negedge clk); t++; end
    repeat (100) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_sd_rd", sd_rd, 0);
    check("mrst_wr_en", wr_en, 0);
    check("mrst_busy", busy, 0);
    check("mrst_disp_bank", disp_bank, 0);
    check("mrst_checksum", checksum, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sd_frame_loader.md
# sd_frame_loader

Parametrised frame loader sitting between `sd_controller` and a multi-bank pixel frame buffer. On a `start` pulse it reads one frame's worth of consecutive SD sectors from a run-time base sector. It packs bytes big-endian into pixels, writes them into the back bank, and keeps a running mod-65521 checksum. On success it swaps the displayed bank so VGA never shows a partial frame. Timeout and abort paths leave the displayed frame untouched.

## Interface
- `PIX_BYTES`, 2: bytes per pixel; 1 or 2. `PIX_W = 8*PIX_BYTES`.
- `FRAME_PIXELS`, 3072: pixels per frame (64x48).
- `NUM_BANKS`, 2: frame banks; ≥2. `BANK_W = clog2(NUM_BANKS)`.
- `SECTOR_BYTES`, 512. `FRAME_PIXELS*PIX_BYTES` must be a multiple of it (elaboration error otherwise). `SECTORS = FRAME_PIXELS*PIX_BYTES/SECTOR_BYTES`.
- `TIMEOUT`, 2^20: idle cycles tolerated while waiting for a byte or for ready.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle request; ignored unless idle.
- `abort` in 1: cancel load; wins over `start` in the same cycle.
- `base_sector` in 32: sampled on accepted `start`.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: sticky timeout flag; cleared by the next accepted `start`.
- `checksum` out 16: sum of pixels mod 65521. Valid from `done` until the next `start`.
- `disp_bank` out BANK_W: bank the display must read.
- `sd_rd` out 1: read pulse to the controller.
- `sd_address` out 32: sector address to the controller.
- `sd_dout` in 8: byte from the controller.
- `sd_byte_available` in 1: byte strobe from the controller.
- `sd_ready` in 1: controller idle.
- `wr_en` out 1: frame buffer write enable.
- `wr_addr` out clog2(NUM_BANKS*FRAME_PIXELS): frame buffer write address.
- `wr_data` out PIX_W: frame buffer write data.

## Operation
- **States:**
  - IDLE
  - WAIT_READY
  - ISSUE
  - RECV
  - FINISH
- **IDLE**
  - On `start`: latch `base_sector`; `load_bank = (disp_bank+1) mod NUM_BANKS`.
  - Clear the sector, byte, pixel and checksum counters; clear `error`; go to WAIT_READY.
- **WAIT_READY:** when `sd_ready=1`, go to ISSUE.
- **ISSUE:**
  - Assert `sd_rd` for exactly one cycle.
  - `sd_address = base + sector_idx`, held stable until the sector's last byte.
  - Go to RECV.
- **RECV:**
  - Each `sd_byte_available` cycle accepts one byte. The first byte of a pixel is the MSB.
  - When a pixel completes, issue one write.
  - After the `SECTOR_BYTES`-th byte:
    - if more sectors remain: `sector_idx++` and go to WAIT_READY;
    - otherwise go to FINISH.
  - `sd_ready` high before all bytes arrive is ignored; the timeout covers it.
- **FINISH:** pulse `done`; `disp_bank <= load_bank`; go to IDLE.
- **Write addressing:** `wr_addr = load_bank*FRAME_PIXELS + pix_idx`, with `pix_idx` running from 0 to FRAME_PIXELS-1.
- **Checksum** (per pixel `p`, zero-extended to 17 bits):
  - `p' = p ≥ 65521 ? p-65521 : p`;
  - `s = sum + p'`;
  - `sum = s ≥ 65521 ? s-65521 : s`.
  - One subtract per step, never a divider.
- **Timeout:** a watchdog counts cycles in WAIT_READY/RECV without progress (a byte, or `sd_ready`). At `TIMEOUT`:
  - `error=1`, go to IDLE, no `done`, `disp_bank` unchanged;
  - partial writes to the back bank are permitted.
- **Abort:** in any non-IDLE state, go to IDLE next cycle with no `done`, no bank swap and no `error`.
- **Restart rules:**
  - `start` while busy is ignored.
  - A new `start` after an abort or error restarts from sector 0 of the new base.
- **Reset:** any state goes to IDLE.
  - Reset values: `busy=0`, `done=0`, `error=0`, `checksum=0`, `disp_bank=0`, `sd_rd=0`, `sd_address=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`.

## Timing
- `busy` is high from the cycle after the accepted `start` through the FINISH cycle.
- `wr_en`/`wr_addr`/`wr_data` are registered: asserted one cycle after the strobe of the pixel's last byte, for one cycle.
- The checksum updates on the `wr_en` cycle (one cycle after the `wr_en` of that pixel).
- Final byte accepted at cycle T:
  - `wr_en` at T+1;
  - FINISH at T+2: `done=1`, final `checksum`, new `disp_bank`;
  - `busy=0` at T+3.
- Minimum spacing of `sd_rd` pulses: one sector plus WAIT_READY + ISSUE (2 cycles).

## Structure
- **Package `sd_frame_pkg`:**
  - state enum;
  - `ADLER_MOD=65521`;
  - default `SECTOR_BYTES=512`;
  - `clog2` helper.
- **Sub-module `mod65521_acc`:** clear, enable, data in; 16-bit registered sum.

## Test plan
- **Full frame, defaults.**
  - Stimulus: `base=100`, byte stream `n mod 256`.
  - Required response:
    - 12 `sd_rd` pulses at addresses 100..111;
    - 3072 writes to addresses 3072..6143, with `wr_data[k] = {(2k)%256, (2k+1)%256}`;
    - `done` with `checksum=22950`;
    - `disp_bank` 0→1.
- **Second load.** Writes go to 0..3071; `disp_bank` 1→0; `done` exactly T+2 after the last byte.
- **All-0xFF frame.** `checksum=43008` (exercises the `p≥65521` pre-reduction).
- **Controller stalls after 300 bytes of sector 3.**
  - `error=1` after `TIMEOUT` cycles; `busy=0`; no `done`; `disp_bank` unchanged.
  - The next `start` clears `error`.
- **Abort / ignored start.**
  - `abort` at pixel 1000: `busy=0` next cycle, `disp_bank` unchanged.
  - `start` during busy has no effect.
  - `start`+`abort` in the same cycle in IDLE: stays IDLE.
- **Reset mid-sector 5.** Next cycle: `sd_rd=0`, `wr_en=0`, `busy=0`, `disp_bank=0`, `checksum=0`.
